// File: rtl/clock_base_top.sv
// UART (8N1) receiver + flag/length frame parser driving the board LEDs from a DEPTH-stage payload shift register.
// Latency: LEDs update 2 cycles after the byte's mid-stop sample; backpressure: none, the serial line cannot be stalled.
module clock_base_top #(
  parameter int         CLKS_PER_BIT = 1736,
  parameter logic [7:0] FLAG         = 8'h7E,
  parameter int         DEPTH        = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       sw,
  input  logic       ct_UartRx,
  output logic [7:0] ct_Led
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD}      parse_state_t;

  rx_state_t    rx_state;
  parse_state_t parse_state;

  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift;
  logic          stop_err;
  logic          rx_valid;
  logic [7:0]    rx_byte;

  logic [7:0]    remaining;
  logic [7:0]    stage [DEPTH];
  logic [7:0]    raw_byte;
  logic [7:0]    frame_byte;

  // Receiver: every sample point is a multiple of CLKS_PER_BIT after the mid-start sample.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      stop_err <= 1'b0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_meta  <= ct_UartRx;
      rx_sync  <= rx_meta;
      rx_valid <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (!rx_sync) begin
            rx_state <= START;
            clk_cnt  <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          // A low stop bit drops the byte and holds off until the line returns high.
          if (stop_err) begin
            if (rx_sync) begin
              stop_err <= 1'b0;
              rx_state <= IDLE;
            end
          end else if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
              rx_state <= IDLE;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      parse_state <= HUNT;
      remaining   <= '0;
      raw_byte    <= '0;
      frame_byte  <= '0;
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (rx_valid) begin
      raw_byte <= rx_byte;
      case (parse_state)
        HUNT: begin
          if (rx_byte == FLAG) parse_state <= LEN;
        end
        LEN: begin
          // The length byte is never a flag, so 0x7E here means 126.
          remaining   <= rx_byte;
          parse_state <= (rx_byte == 8'd0) ? HUNT : PAYLOAD;
        end
        PAYLOAD: begin
          stage[0] <= rx_byte;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
            frame_byte  <= rx_byte;
            parse_state <= HUNT;
          end
        end
        default: parse_state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) ct_Led <= 8'h00;
    else       ct_Led <= sw ? raw_byte : frame_byte;
  end

endmodule

// File: tb/tb_clock_base_top.sv
// Bench for clock_base_top with a shortened bit time; received bytes are scoreboarded, LED/stage values checked after each step.
module tb_clock_base_top;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       reset;
  logic       sw;
  logic       ct_UartRx;
  logic [7:0] ct_Led;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  always #5 CLK = ~CLK;

  clock_base_top #(.CLKS_PER_BIT(CPB), .FLAG(8'h7E), .DEPTH(8)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .sw       (sw),
    .ct_UartRx(ct_UartRx),
    .ct_Led   (ct_Led)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Every received byte must match the oldest outstanding sent byte.
  always @(negedge CLK) begin
    if (!reset && dut.rx_valid === 1'b1) begin
      check_eq("rx_pending", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) check_eq("rx_byte", dut.rx_byte, exp_q.pop_front());
    end
  end

  task automatic uart_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) exp_q.push_back(b);
    @(negedge CLK);
    ct_UartRx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      ct_UartRx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    ct_UartRx = stop_bit;
    repeat (CPB) @(negedge CLK);
    ct_UartRx = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    uart_frame(b, 1'b1);
  endtask

  task automatic set_sw(input logic v);
    @(negedge CLK);
    sw = v;
    @(negedge CLK);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    sw = 1'b0;
    ct_UartRx = 1'b1;
    repeat (10) @(negedge CLK);
    check_eq("reset_led", ct_Led, 8'h00);
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    check_eq("idle_led", ct_Led, 8'h00);

    // Stray byte outside any frame
    send(8'hF4);
    check_eq("stray_sw0", ct_Led, 8'h00);
    set_sw(1'b1);
    check_eq("stray_sw1", ct_Led, 8'hF4);
    set_sw(1'b0);

    // First frame
    foreach (exp_q[i]) begin end
    send(8'h7E); send(8'h03); send(8'h55); send(8'h57); send(8'h41);
    check_eq("frame1_led", ct_Led, 8'h41);
    check_eq("frame1_st0", dut.stage[0], 8'h41);
    check_eq("frame1_st1", dut.stage[1], 8'h57);
    check_eq("frame1_st2", dut.stage[2], 8'h55);

    // Second frame, held display until its last byte
    send(8'h7E); send(8'h04); send(8'hC0); send(8'hF0); send(8'hFC);
    check_eq("frame2_hold", ct_Led, 8'h41);
    send(8'hFF);
    check_eq("frame2_led", ct_Led, 8'hFF);
    check_eq("frame2_st3", dut.stage[3], 8'hC0);

    // Framing error, then a good byte
    set_sw(1'b1);
    check_eq("raw_before_ferr", ct_Led, 8'hFF);
    uart_frame(8'h33, 1'b0);
    check_eq("ferr_dropped", ct_Led, 8'hFF);
    send(8'hA5);
    check_eq("after_ferr", ct_Led, 8'hA5);

    // Short low glitch must not start a byte
    @(negedge CLK);
    ct_UartRx = 1'b0;
    repeat (3) @(negedge CLK);
    ct_UartRx = 1'b1;
    repeat (12 * CPB) @(negedge CLK);
    check_eq("glitch_led", ct_Led, 8'hA5);
    send(8'h5C);
    check_eq("after_glitch", ct_Led, 8'h5C);

    // Zero length frame, trailing byte ignored in HUNT
    set_sw(1'b0);
    send(8'h7E); send(8'h00); send(8'h12);
    check_eq("zero_len_led", ct_Led, 8'hFF);
    set_sw(1'b1);
    check_eq("zero_len_raw", ct_Led, 8'h12);
    set_sw(1'b0);

    // Flag value as payload data
    send(8'h7E); send(8'h01); send(8'h7E);
    check_eq("flag_as_data", ct_Led, 8'h7E);

    // Length 10 keeps only the newest 8
    send(8'h7E); send(8'h0A);
    for (int k = 1; k <= 10; k++) send(8'(k));
    check_eq("long_led", ct_Led, 8'h0A);
    check_eq("long_st0", dut.stage[0], 8'h0A);
    check_eq("long_st7", dut.stage[7], 8'h03);

    // Length byte equal to the flag means 126
    send(8'h7E); send(8'h7E);
    for (int k = 1; k <= 125; k++) send(8'(k));
    check_eq("len126_hold", ct_Led, 8'h0A);
    send(8'h7E);
    check_eq("len126_led", ct_Led, 8'h7E);
    check_eq("len126_st1", dut.stage[1], 8'h7D);
    send(8'h7E); send(8'h01); send(8'h99);
    check_eq("after_len126", ct_Led, 8'h99);

    // Reset mid-frame abandons it; a fresh flag is needed
    send(8'h7E); send(8'h05); send(8'h11); send(8'h22);
    @(negedge CLK);
    reset = 1'b1;
    repeat (10) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check_eq("midrst_led", ct_Led, 8'h00);
    check_eq("midrst_st0", dut.stage[0], 8'h00);
    send(8'h33); send(8'h44); send(8'h55); send(8'h01); send(8'h02);
    check_eq("midrst_noflag", ct_Led, 8'h00);
    send(8'h7E); send(8'h01); send(8'h66);
    check_eq("midrst_newframe", ct_Led, 8'h66);

    repeat (20) @(negedge CLK);
    check_eq("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
